// File: rtl/dcm_lock_sequencer_pkg.sv
// Shared definitions for the DCM lock sequencer: state encodings seen on the
// status readback port and the retry counter width.
package dcm_lock_sequencer_pkg;

    localparam int RETRY_BITS = 4;
    localparam int STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } seq_state_t;

    // DCM RST is held in both the deliberate reset window and the parked fault state.
    function automatic logic drives_dcm_rst(input seq_state_t s);
        return (s == ST_RST_ASSERT) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/dcm_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and the board-level
// clocking logic (DCM RST/LOCKED, BUFGCE enable, status readback).
interface dcm_lock_sequencer_if
    import dcm_lock_sequencer_pkg::*;
#(
    parameter int NUM_DCM = 2
);
    logic                  restart;
    logic [NUM_DCM-1:0]    dcm_locked;
    logic                  dcm_rst;
    logic                  clk_ready;
    logic                  lock_fault;
    logic [RETRY_BITS-1:0] retry_count;
    logic [STATE_BITS-1:0] state;

    modport master (
        input  restart,
        input  dcm_locked,
        output dcm_rst,
        output clk_ready,
        output lock_fault,
        output retry_count,
        output state
    );

    modport slave (
        output restart,
        output dcm_locked,
        input  dcm_rst,
        input  clk_ready,
        input  lock_fault,
        input  retry_count,
        input  state
    );
endinterface

// File: rtl/dcm_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for one asynchronous LOCKED bit; clears to 0 so a
// reset never reports a lock that has not been re-observed.
module dcm_lock_sequencer_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/dcm_lock_sequencer.sv
// Supervises the DCM_SP clock generators: pulses RST, waits for and qualifies
// LOCKED, raises clk_ready, and retries a bounded number of times before parking.
module dcm_lock_sequencer
    import dcm_lock_sequencer_pkg::*;
#(
    parameter int NUM_DCM       = 2,
    parameter int CNT_BITS      = 20,
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 320000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    dcm_lock_sequencer_if.master        bus
);
    localparam logic [CNT_BITS-1:0]   RST_LAST     = CNT_BITS'(RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]   TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0]   STABLE_LAST  = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [RETRY_BITS-1:0] RETRY_LIMIT  = RETRY_BITS'(MAX_RETRIES);

    logic [NUM_DCM-1:0] locked_sync;
    logic               locked_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DCM; gi++) begin : g_sync
            dcm_lock_sequencer_sync_2ff u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (bus.dcm_locked[gi]),
                .q       (locked_sync[gi])
            );
        end
    endgenerate

    assign locked_s = &locked_sync;

    seq_state_t            state_reg,       state_next;
    logic [CNT_BITS-1:0]   counter_reg,     counter_next;
    logic [RETRY_BITS-1:0] retry_count_reg, retry_count_next;
    logic                  dcm_rst_reg,     dcm_rst_next;
    logic                  clk_ready_reg,   clk_ready_next;
    logic                  lock_fault_reg,  lock_fault_next;
    logic                  retry_req;

    always_comb begin
        state_next       = state_reg;
        retry_count_next = retry_count_reg;
        retry_req        = 1'b0;

        if (bus.restart) begin
            state_next       = ST_RST_ASSERT;
            retry_count_next = '0;
        end else begin
            // Lock loss is tested before terminal count so it wins a same-cycle tie.
            case (state_reg)
                ST_RST_ASSERT: begin
                    if (counter_reg == RST_LAST)
                        state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s)
                        state_next = ST_STABLE;
                    else if (counter_reg == TIMEOUT_LAST)
                        retry_req = 1'b1;
                end
                ST_STABLE: begin
                    if (!locked_s)
                        retry_req = 1'b1;
                    else if (counter_reg == STABLE_LAST)
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s)
                        retry_req = 1'b1;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_RST_ASSERT;
                end
            endcase

            if (retry_req) begin
                if (retry_count_reg == RETRY_LIMIT) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next       = ST_RST_ASSERT;
                    retry_count_next = retry_count_reg + RETRY_BITS'(1);
                end
            end
        end

        counter_next = (bus.restart || (state_next != state_reg)) ?
                       '0 : counter_reg + CNT_BITS'(1);

        // Outputs are decoded from the next state so each one lands in its own flop.
        dcm_rst_next    = drives_dcm_rst(state_next);
        clk_ready_next  = (state_next == ST_RUN);
        lock_fault_next = (state_next == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_RST_ASSERT;
            counter_reg     <= '0;
            retry_count_reg <= '0;
            dcm_rst_reg     <= 1'b1;
            clk_ready_reg   <= 1'b0;
            lock_fault_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            retry_count_reg <= retry_count_next;
            dcm_rst_reg     <= dcm_rst_next;
            clk_ready_reg   <= clk_ready_next;
            lock_fault_reg  <= lock_fault_next;
        end
    end

    assign bus.dcm_rst     = dcm_rst_reg;
    assign bus.clk_ready   = clk_ready_reg;
    assign bus.lock_fault  = lock_fault_reg;
    assign bus.retry_count = retry_count_reg;
    assign bus.state       = state_reg;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Self-checking bench for dcm_lock_sequencer: directed boot/retry/fault/restart
// scenarios plus a randomized lock/restart phase, all checked against a timeline model.
module tb_dcm_lock_sequencer;
    localparam int NUM_DCM       = 2;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic clk = 1'b0;
    logic reset_n;

    dcm_lock_sequencer_if #(.NUM_DCM(NUM_DCM)) bus ();

    dcm_lock_sequencer #(
        .NUM_DCM       (NUM_DCM),
        .CNT_BITS      (20),
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase number, edge index at which the phase was entered,
    // and the history of AND-ed lock samples (visible two edges later).
    int m_phase   = P_RST;
    int m_start   = 0;
    int m_cyc     = 0;
    int m_retries = 0;
    bit hist[$];

    task automatic m_enter(input int p);
        m_phase = p;
        m_start = m_cyc;
    endtask

    task automatic m_retry();
        if (m_retries == MAX_RETRIES) begin
            m_enter(P_FAULT);
        end else begin
            m_retries = m_retries + 1;
            m_enter(P_RST);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        bit ls;
        int age;
        if (!reset_n) begin
            m_phase   = P_RST;
            m_retries = 0;
            m_start   = m_cyc;
            hist      = '{1'b0, 1'b0};
        end else begin
            m_cyc = m_cyc + 1;
            age   = m_cyc - m_start - 1;
            ls    = hist.pop_front();
            hist.push_back(&bus.dcm_locked);
            if (bus.restart) begin
                m_retries = 0;
                m_enter(P_RST);
            end else if (m_phase == P_RST) begin
                if (age == RST_CYCLES - 1) m_enter(P_WAIT);
            end else if (m_phase == P_WAIT) begin
                if (ls) m_enter(P_STABLE);
                else if (age == LOCK_TIMEOUT - 1) m_retry();
            end else if (m_phase == P_STABLE) begin
                if (!ls) m_retry();
                else if (age == STABLE_CYCLES - 1) m_enter(P_RUN);
            end else if (m_phase == P_RUN) begin
                if (!ls) m_retry();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("state",       32'(bus.state),       m_phase);
        chk("dcm_rst",     32'(bus.dcm_rst),     32'((m_phase == P_RST) || (m_phase == P_FAULT)));
        chk("clk_ready",   32'(bus.clk_ready),   32'(m_phase == P_RUN));
        chk("lock_fault",  32'(bus.lock_fault),  32'(m_phase == P_FAULT));
        chk("retry_count", 32'(bus.retry_count), m_retries);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while ((32'(bus.state) != s) && (n < budget)) begin
            run(1);
            n = n + 1;
        end
        chk("wait_state", 32'(bus.state), s);
    endtask

    task automatic measure_rst_pulse(input string tag);
        int width = 1;
        for (int i = 0; i < 20; i++) begin
            run(1);
            if (bus.dcm_rst) width = width + 1;
            else break;
        end
        chk(tag, width, RST_CYCLES);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r;

        reset_n        = 1'b0;
        bus.restart    = 1'b0;
        bus.dcm_locked = '0;
        repeat (3) @(negedge clk);
        chk("reset_state",   32'(bus.state),       P_RST);
        chk("reset_dcm_rst", 32'(bus.dcm_rst),     1);
        chk("reset_ready",   32'(bus.clk_ready),   0);
        chk("reset_fault",   32'(bus.lock_fault),  0);
        chk("reset_retries", 32'(bus.retry_count), 0);

        // Normal boot: release before edge 0, locks sampled from edge 10.
        reset_n = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            run(1);
            if (k == 9)  bus.dcm_locked = '1;
            if (k == 2)  chk("boot_rst_e2",   32'(bus.dcm_rst), 1);
            if (k == 3)  chk("boot_rst_e3",   32'(bus.dcm_rst), 0);
            if (k == 11) chk("boot_wait_e11", 32'(bus.state), P_WAIT);
            if (k == 12) chk("boot_stable_e12", 32'(bus.state), P_STABLE);
            if (k == 19) chk("boot_ready_e19", 32'(bus.clk_ready), 0);
            if (k == 20) begin
                chk("boot_ready_e20", 32'(bus.clk_ready), 1);
                chk("boot_retries",   32'(bus.retry_count), 0);
            end
        end

        // Lock loss in RUN: clk_ready drops on the third edge after the fall.
        run(5);
        bus.dcm_locked = 2'b01;
        run(2);
        chk("run_loss_ready_held", 32'(bus.clk_ready), 1);
        run(1);
        chk("run_loss_ready_fell", 32'(bus.clk_ready), 0);
        chk("run_loss_retries",    32'(bus.retry_count), 1);
        chk("run_loss_dcm_rst",    32'(bus.dcm_rst), 1);
        bus.dcm_locked = '1;
        measure_rst_pulse("run_loss_rst_width");
        wait_state(P_RUN, 60);

        // One-cycle glitch on bit 1 during STABLE.
        bus.restart = 1'b1;
        run(1);
        bus.restart = 1'b0;
        chk("restart_clears_retries", 32'(bus.retry_count), 0);
        wait_state(P_STABLE, 40);
        run(2);
        bus.dcm_locked = 2'b01;
        run(1);
        bus.dcm_locked = '1;
        wait_state(P_RST, 10);
        chk("glitch_retries", 32'(bus.retry_count), 1);
        chk("glitch_ready",   32'(bus.clk_ready), 0);
        measure_rst_pulse("glitch_rst_width");
        wait_state(P_RUN, 60);

        // Restart held high parks the sequencer in reset assertion.
        bus.restart = 1'b1;
        run(10);
        bus.restart    = 1'b0;
        bus.dcm_locked = 2'b01;

        // One DCM never locks: timeouts exhaust the retry budget.
        wait_state(P_FAULT, 200);
        chk("fault_flag",    32'(bus.lock_fault),  1);
        chk("fault_retries", 32'(bus.retry_count), MAX_RETRIES);
        chk("fault_dcm_rst", 32'(bus.dcm_rst),     1);
        chk("fault_ready",   32'(bus.clk_ready),   0);
        run(40);

        // Restart out of FAULT replays the full sequence.
        bus.dcm_locked = '1;
        bus.restart    = 1'b1;
        run(1);
        bus.restart = 1'b0;
        chk("fault_restart_flag",    32'(bus.lock_fault),  0);
        chk("fault_restart_retries", 32'(bus.retry_count), 0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            lat = lat + 1;
            if (bus.clk_ready) break;
        end
        chk("restart_to_ready_latency", lat, RST_CYCLES + 1 + STABLE_CYCLES);

        // Randomized lock drops and restarts.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            bus.restart = (r < 3);
            if (r >= 90)      bus.dcm_locked = NUM_DCM'($urandom);
            else if (r >= 80) bus.dcm_locked = '1;
            run(1);
        end
        bus.restart = 1'b0;

        // Asynchronous reset between edges while waiting for lock.
        bus.dcm_locked = '0;
        bus.restart    = 1'b1;
        run(1);
        bus.restart = 1'b0;
        wait_state(P_WAIT, 10);
        wait_state(P_RST, 30);
        wait_state(P_WAIT, 10);
        chk("pre_reset_retries", 32'(bus.retry_count), 1);
        run(3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state",   32'(bus.state),       P_RST);
        chk("async_dcm_rst", 32'(bus.dcm_rst),     1);
        chk("async_ready",   32'(bus.clk_ready),   0);
        chk("async_fault",   32'(bus.lock_fault),  0);
        chk("async_retries", 32'(bus.retry_count), 0);
        run(2);
        reset_n        = 1'b1;
        bus.dcm_locked = '1;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
